// File: rtl/nios_cpu_mult_pkg.sv
// Shared types and helpers for the Nios CPU pipelined multiplier.
// Mode decode lives here so that the datapath and any consumer agree on what each mode means.
package nios_cpu_mult_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SLICE_W_DEF = 16;
  localparam int TAG_W_DEF   = 5;
  localparam int NUM_SLICES  = DATA_W_DEF / SLICE_W_DEF;
  localparam int PROD_W      = 2 * DATA_W_DEF;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULXUU = 2'b01,
    MODE_MULXSU = 2'b10,
    MODE_MULXSS = 2'b11
  } mode_e;

  function automatic logic mode_signed_a(mode_e m);
    return (m == MODE_MULXSU) || (m == MODE_MULXSS);
  endfunction

  function automatic logic mode_signed_b(mode_e m);
    return (m == MODE_MULXSS);
  endfunction

  function automatic logic mode_hi(mode_e m);
    return (m != MODE_MUL);
  endfunction

endpackage

// File: rtl/nios_cpu_mult_unit_slice.sv
// Registered unsigned SLICE_W x SLICE_W multiplier with clock enable.
// Sized to map onto a single DSP block.
module nios_cpu_mult_slice #(
  parameter int SLICE_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [SLICE_W-1:0]   a,
  input  logic [SLICE_W-1:0]   b,
  output logic [2*SLICE_W-1:0] p
);

  logic [2*SLICE_W-1:0] p_q, p_d;

  always_comb begin
    p_d = p_q;
    if (en) p_d = (2*SLICE_W)'(a) * (2*SLICE_W)'(b);
  end

  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/nios_cpu_mult_unit.sv
// Two-stage pipelined multiplier: S1 registers slice products and sign corrections,
// S2 registers the summed product half selected by the mode.
module nios_cpu_mult_unit
  import nios_cpu_mult_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int N_SL = DATA_W / SLICE_W;
  localparam int P_W  = 2 * DATA_W;

  logic adv1, adv2;
  mode_e in_mode_e;

  logic s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] corr_q, corr_d, corr_in;
  mode_e mode_q, mode_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [N_SL*N_SL-1:0][2*SLICE_W-1:0] prod;
  logic [P_W-1:0] prod_sum;

  assign adv2      = !out_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign in_mode_e = mode_e'(in_mode);

  for (genvar gi = 0; gi < N_SL; gi++) begin : g_row
    for (genvar gj = 0; gj < N_SL; gj++) begin : g_col
      nios_cpu_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
        .clk   (clk),
        .reset (reset),
        .en    (adv1),
        .a     (in_a[gi*SLICE_W +: SLICE_W]),
        .b     (in_b[gj*SLICE_W +: SLICE_W]),
        .p     (prod[gi*N_SL+gj])
      );
    end
  end

  // Signed operands are folded in as a subtraction from the upper half; mod 2^DATA_W suffices.
  always_comb begin
    corr_in = '0;
    if (mode_signed_a(in_mode_e) && in_a[DATA_W-1]) corr_in = corr_in + in_b;
    if (mode_signed_b(in_mode_e) && in_b[DATA_W-1]) corr_in = corr_in + in_a;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    corr_d     = corr_q;
    mode_d     = mode_q;
    s1_tag_d   = s1_tag_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      corr_d     = corr_in;
      mode_d     = in_mode_e;
      s1_tag_d   = in_tag;
    end
    if (flush) s1_valid_d = 1'b0;
  end

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < N_SL; i++)
      for (int j = 0; j < N_SL; j++)
        prod_sum = prod_sum + (P_W'(prod[i*N_SL+j]) << ((i + j) * SLICE_W));
    prod_sum = prod_sum - {corr_q, {DATA_W{1'b0}}};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    tag_d       = tag_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      result_d    = mode_hi(mode_q) ? prod_sum[P_W-1:DATA_W] : prod_sum[DATA_W-1:0];
      tag_d       = s1_tag_q;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      corr_q      <= '0;
      mode_q      <= MODE_MUL;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      corr_q      <= corr_d;
      mode_q      <= mode_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_nios_cpu_mult_unit.sv
// Directed table, handshake corner sequences and random traffic against a 64-bit product model.
module tb_nios_cpu_mult_unit;

  localparam int DW = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [1:0] in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;

  logic [63:0] w_a = '0, w_b = '0;
  logic [1:0] w_mode = '0;
  logic w_valid = 1'b0;
  logic w_ready, w_ovalid;
  logic [63:0] w_result;
  logic [TW-1:0] w_tag;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  nios_cpu_mult_unit #(.DATA_W(DW), .SLICE_W(16), .TAG_W(TW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  nios_cpu_mult_unit #(.DATA_W(64), .SLICE_W(16), .TAG_W(TW)) u_dut64 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(w_valid), .in_ready(w_ready),
    .in_a(w_a), .in_b(w_b), .in_mode(w_mode), .in_tag(5'd0),
    .out_valid(w_ovalid), .out_ready(1'b1), .out_result(w_result), .out_tag(w_tag)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    logic [63:0] ax, bx, p;
    ax = (m == 2'b10 || m == 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    bx = (m == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (m != 2'b00) ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: expected results queued at accept, retired on output handshake.
  typedef struct packed { logic [31:0] res; logic [TW-1:0] tag; } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (reset) sb_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_spurious actual=%h required=none", out_result);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_result", {32'b0, out_result}, {32'b0, sb_e.res});
          check("sb_tag", {59'b0, out_tag}, {59'b0, sb_e.tag});
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back('{res: ref_mul(in_a, in_b, in_mode), tag: in_tag});
    end
  end

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic [TW-1:0] t, input logic [31:0] exp, input string nm);
    int n;
    tick();
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_tag = t;
    @(negedge clk);
    check({nm, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin tick(); n++; end
    check({nm, "_latency"}, 64'(n), 64'd2);
    check({nm, "_result"}, {32'b0, out_result}, {32'b0, exp});
    check({nm, "_tag"}, {59'b0, out_tag}, {59'b0, t});
  endtask

  typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] m; logic [31:0] exp; } vec_t;
  vec_t tbl[14];

  logic [31:0] bp_a[3];
  int acc, n_out, first_cyc;

  initial begin
    tbl[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE};
    tbl[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001};
    tbl[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000};
    tbl[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF};
    tbl[4]  = '{32'h80000000, 32'h80000000, 2'b11, 32'h40000000};
    tbl[5]  = '{32'h80000000, 32'h80000000, 2'b10, 32'hC0000000};
    tbl[6]  = '{32'h80000000, 32'h80000000, 2'b01, 32'h40000000};
    tbl[7]  = '{32'h00000003, 32'h00000005, 2'b00, 32'h0000000F};
    tbl[8]  = '{32'h00010000, 32'h00010000, 2'b01, 32'h00000001};
    tbl[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 2'b11, 32'h3FFFFFFF};
    tbl[10] = '{32'h00000002, 32'hFFFFFFFF, 2'b10, 32'h00000001};
    tbl[11] = '{32'hFFFFFFFF, 32'h00000002, 2'b11, 32'hFFFFFFFF};
    tbl[12] = '{32'h12345678, 32'h00000000, 2'b11, 32'h00000000};
    tbl[13] = '{32'hFFFFFFFF, 32'h00000002, 2'b01, 32'h00000001};

    repeat (3) tick();
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_result", {32'b0, out_result}, 64'd0);
    check("rst_out_tag", {59'b0, out_tag}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // 64-bit configuration
    tick(); w_valid = 1'b1; w_a = 64'h8000000000000000; w_b = 64'h8000000000000000; w_mode = 2'b11;
    tick(); w_a = 64'hFFFFFFFFFFFFFFFF; w_b = 64'hFFFFFFFFFFFFFFFF; w_mode = 2'b01;
    tick(); w_valid = 1'b0;
    check("w64_ss_valid", {63'b0, w_ovalid}, 64'd1);
    check("w64_ss_result", w_result, 64'h4000000000000000);
    check("w64_in_ready", {63'b0, w_ready}, 64'd1);
    tick();
    check("w64_uu_result", w_result, 64'hFFFFFFFFFFFFFFFE);

    out_ready = 1'b1;
    for (int k = 0; k < 14; k++)
      run_one(tbl[k].a, tbl[k].b, tbl[k].m, TW'(k), tbl[k].exp, $sformatf("vec%0d", k));
    tick();

    // Streaming: 8 back-to-back ops
    n_out = 0; first_cyc = -1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          tick();
          in_valid = 1'b1; in_a = 32'(k + 1); in_b = 32'(k * 3 + 7); in_mode = 2'(k); in_tag = TW'(k + 8);
          @(negedge clk);
          check("stream_in_ready", {63'b0, in_ready}, 64'd1);
        end
        tick();
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (first_cyc < 0) first_cyc = c;
            check("stream_tag", {59'b0, out_tag}, 64'(n_out + 8));
            check("stream_consecutive", 64'(c), 64'(first_cyc + n_out));
            n_out++;
          end
        end
      end
    join
    check("stream_count", 64'(n_out), 64'd8);

    // Backpressure: 3 ops offered while out_ready=0
    bp_a[0] = 32'h11111111; bp_a[1] = 32'h22222222; bp_a[2] = 32'h33333333;
    out_ready = 1'b0; acc = 0;
    tick();
    in_valid = 1'b1; in_a = bp_a[0]; in_b = 32'h00000010; in_mode = 2'b00; in_tag = 5'd20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      tick();
      in_valid = (acc < 3);
      if (acc < 3) begin in_a = bp_a[acc]; in_tag = TW'(20 + acc); end
    end
    check("bp_accepts", 64'(acc), 64'd2);
    @(negedge clk);
    check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      tick();
      in_valid = (acc < 3);
    end
    check("bp_third_accept", 64'(acc), 64'd3);
    repeat (4) tick();
    check("bp_drained", 64'(sb_q.size()), 64'd0);

    // Flush with both stages full and a concurrent offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h5; in_b = 32'h6; in_mode = 2'b00; in_tag = 5'd1;
    tick(); in_tag = 5'd2; in_a = 32'h7;
    tick(); in_valid = 1'b0;
    tick();
    check("fl_full_valid", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_tag = 5'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {63'b0, out_valid}, 64'd0);
    n_out = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (out_valid) n_out++; end
    check("fl_nothing_accepted", 64'(n_out), 64'd0);

    // Synchronous reset mid-stream
    in_valid = 1'b1; in_a = 32'h1234; in_b = 32'h5678; in_mode = 2'b00; in_tag = 5'd9;
    tick(); in_tag = 5'd10;
    tick(); in_tag = 5'd11;
    tick(); in_valid = 1'b0; reset = 1'b1;
    tick();
    check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_out_result", {32'b0, out_result}, 64'd0);
    check("mid_rst_out_tag", {59'b0, out_tag}, 64'd0);
    reset = 1'b0;
    run_one(32'h00000010, 32'h00000020, 2'b00, 5'd17, 32'h00000200, "post_rst");
    tick();

    // Random traffic
    acc = 0;
    for (int c = 0; c < 60000 && acc < 10000; c++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      in_a = rand_op(); in_b = rand_op(); in_mode = 2'($urandom_range(0, 3)); in_tag = TW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready && !flush) acc++;
    end
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("rnd_accepts", 64'(acc), 64'd10000);
    check("rnd_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
